// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared sizes, FSM state encoding and checksum operator for the imem boot loader
package imem_boot_loader_pkg;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam int LEN_MIN = 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN = 3'd1;
  localparam logic [2:0] S_LO = 3'd2;
  localparam logic [2:0] S_HI = 3'd3;
  localparam logic [2:0] S_CHK = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR = 3'd6;
  function automatic logic [BYTE_W-1:0] csum_op(input logic [BYTE_W-1:0] a, input logic [BYTE_W-1:0] b);
    return a ^ b;
  endfunction
endpackage

// File: rtl/imem_boot_loader_byte_pair_assembler.sv
// imem_boot_loader_byte_pair_assembler: latches lo byte, emits {hi,lo} word with 1-cycle imem_we at the running address; ports clk rst clr lo_we hi_we byte_in -> imem_we imem_addr imem_wdata words_loaded
module imem_boot_loader_byte_pair_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              lo_we,
  input  logic              hi_we,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [ADDR_W:0]   words_loaded
);
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  always_comb begin
    lo_d = lo_we ? byte_in : lo_q;
    we_d = hi_we;
    addr_d = hi_we ? cnt_q[ADDR_W-1:0] : addr_q;
    wdata_d = hi_we ? {byte_in, lo_q} : wdata_q;
    cnt_d = clr ? '0 : hi_we ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      lo_q <= lo_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
    end
  end
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign words_loaded = cnt_q;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: frame FSM (LEN, words lo/hi, XOR checksum) loading imem and holding the core; ports clk rst load_start byte_valid byte_in -> imem_we imem_addr imem_wdata cpu_hold load_done load_err words_loaded
module imem_boot_loader
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  logic [2:0] state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic lo_we, hi_we, len_ok;
  assign len_ok = byte_in >= BYTE_W'(LEN_MIN) && byte_in <= BYTE_W'(DEPTH);
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    csum_d = csum_q;
    hold_d = hold_q;
    done_d = done_q;
    err_d = err_q;
    lo_we = 1'b0;
    hi_we = 1'b0;
    if (load_start) begin
      state_d = S_LEN;
      csum_d = '0;
      hold_d = 1'b1;
      done_d = 1'b0;
      err_d = 1'b0;
    end else if (byte_valid) begin
      case (state_q)
        S_LEN: begin
          len_d = len_ok ? byte_in[ADDR_W:0] : len_q;
          state_d = len_ok ? S_LO : S_ERR;
          err_d = !len_ok;
        end
        S_LO: begin
          lo_we = 1'b1;
          csum_d = csum_op(csum_q, byte_in);
          state_d = S_HI;
        end
        S_HI: begin
          hi_we = 1'b1;
          csum_d = csum_op(csum_q, byte_in);
          state_d = (words_loaded + 1'b1 == len_q) ? S_CHK : S_LO;
        end
        S_CHK: begin
          state_d = (byte_in == csum_q) ? S_DONE : S_ERR;
          done_d = byte_in == csum_q;
          err_d = byte_in != csum_q;
          hold_d = byte_in != csum_q;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q <= '0;
      csum_q <= '0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      csum_q <= csum_d;
      hold_q <= hold_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  imem_boot_loader_byte_pair_assembler u_bpa (
    .clk(clk),
    .rst(rst),
    .clr(load_start),
    .lo_we(lo_we),
    .hi_we(hi_we),
    .byte_in(byte_in),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .words_loaded(words_loaded)
  );
  assign cpu_hold = hold_q;
  assign load_done = done_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized frame stimulus with a write scoreboard and frame-level status model
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst, load_start, byte_valid;
  logic [7:0] byte_in;
  logic imem_we, cpu_hold, load_done, load_err;
  logic [3:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [4:0] words_loaded;
  typedef struct {
    logic [3:0] a;
    logic [15:0] d;
    int c;
  } wr_t;
  wr_t q[$];
  wr_t mon_e;
  int cyc = 0, checks = 0, failures = 0;
  logic [4:0] wa;
  logic [15:0] words[16];
  imem_boot_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid), .byte_in(byte_in),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (imem_we !== 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write we=%b addr=%0h data=%h cyc=%0d", imem_we, imem_addr, imem_wdata, cyc);
      end else begin
        mon_e = q.pop_front();
        if (imem_addr !== mon_e.a || imem_wdata !== mon_e.d || cyc != mon_e.c) begin
          failures++;
          $display("FAIL write got addr=%0h data=%h cyc=%0d exp addr=%0h data=%h cyc=%0d",
                   imem_addr, imem_wdata, cyc, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask
  task automatic status(input string n, input bit d, input bit e, input bit h, input int wl);
    chk({n, "_done"}, 16'(load_done), 16'(d));
    chk({n, "_err"}, 16'(load_err), 16'(e));
    chk({n, "_hold"}, 16'(cpu_hold), 16'(h));
    chk({n, "_words"}, 16'(words_loaded), 16'(wl));
  endtask
  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    wa = '0;
  endtask
  task automatic send(input logic [7:0] b, input bit push, input logic [15:0] d, input bit fast);
    byte_in = b;
    byte_valid = 1'b1;
    if (push) begin
      q.push_back('{wa[3:0], d, cyc + 1});
      wa++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (!fast) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask
  task automatic body(input int n, input bit fast, output logic [7:0] cs);
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      send(words[i][7:0], 1'b0, 16'h0, fast);
      send(words[i][15:8], 1'b1, words[i], fast);
      cs = cs ^ words[i][7:0] ^ words[i][15:8];
    end
  endtask
  task automatic frame(input string n, input logic [7:0] lb, input bit bad, input bit fast);
    logic [7:0] cs;
    start();
    send(lb, 1'b0, 16'h0, fast);
    if (lb >= 8'd1 && lb <= 8'd16) begin
      body(int'(lb), fast, cs);
      send(bad ? cs ^ 8'h01 : cs, 1'b0, 16'h0, fast);
      repeat (2) @(negedge clk);
      status(n, !bad, bad, bad, int'(lb));
    end else begin
      send(8'($urandom), 1'b0, 16'h0, fast);
      send(8'($urandom), 1'b0, 16'h0, fast);
      repeat (2) @(negedge clk);
      status(n, 1'b0, 1'b1, 1'b1, 0);
    end
  endtask
  initial begin
    logic [7:0] cs, lb;
    rst = 1'b1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    wa = '0;
    repeat (2) @(negedge clk);
    chk("rst_we", 16'(imem_we), 16'h0);
    chk("rst_addr", 16'(imem_addr), 16'h0);
    chk("rst_wdata", imem_wdata, 16'h0);
    status("rst", 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    @(negedge clk);
    words[0] = 16'h0123;
    words[1] = 16'h1234;
    frame("t1", 8'h02, 1'b0, 1'b0);
    frame("t2a", 8'h00, 1'b0, 1'b0);
    frame("t2b", 8'h11, 1'b0, 1'b0);
    frame("t3", 8'h02, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
    frame("t4", 8'h10, 1'b0, 1'b1);
    start();
    send(8'h03, 1'b0, 16'h0, 1'b0);
    body(1, 1'b0, cs);
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;
    wa = '0;
    status("t5_abort", 1'b0, 1'b0, 1'b1, 0);
    send(8'h01, 1'b0, 16'h0, 1'b0);
    words[0] = 16'hBEEF;
    body(1, 1'b0, cs);
    send(cs, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    status("t5_good", 1'b1, 1'b0, 1'b0, 1);
    start();
    send(8'h02, 1'b0, 16'h0, 1'b0);
    send(8'h5A, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    byte_in = 8'hC3;
    byte_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    chk("t6_we", 16'(imem_we), 16'h0);
    chk("t6_addr", 16'(imem_addr), 16'h0);
    chk("t6_wdata", imem_wdata, 16'h0);
    status("t6", 1'b0, 1'b0, 1'b0, 0);
    send(8'h77, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    status("t6_idle", 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
      lb = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)))
                                       : 8'($urandom_range(1, 16));
      frame("rnd", lb, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_writes got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
